system_ram_arbiter: RTL and testbench
=====================================

// Module: system_ram_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter in front of the 1024x32 single-port on-chip RAM (system_RAM).
//  Shares the RAM's single port between master 0 (CPU data) and master 1 (DMA/alarm logic).
//  Grants one access per clk. Round-robin by default. Returns read data with a fixed 1-cycle latency.
// PARAMETERS
//  ADDR_W   10   word address width; 1024 words
//  DATA_W   32   data width; BE_W = DATA_W/8 = 4
// PORTS
//  clk                 in   1       system clock; all logic on rising edge
//  reset               in   1       synchronous, active-high reset
//  m0_/m1_address      in   ADDR_W  word address per master
//  m0_/m1_byteenable   in   BE_W    byte lanes for writes; ignored on reads
//  m0_/m1_read         in   1       read request; held until accepted
//  m0_/m1_write        in   1       write request; held until accepted
//  m0_/m1_writedata    in   DATA_W  write data
//  m0_/m1_waitrequest  out  1       1 = request not accepted this cycle
//  m0_/m1_readdata     out  DATA_W  read data; valid only with readdatavalid
//  m0_/m1_readdatavalid out 1       1-cycle pulse, one per accepted read
//  freeze              in   1       1 = accept no new requests
//  ram_address         out  ADDR_W  to RAM address
//  ram_byteenable      out  BE_W    to RAM byteenable
//  ram_chipselect      out  1       to RAM chipselect
//  ram_write           out  1       to RAM write
//  ram_writedata       out  DATA_W  to RAM writedata
//  ram_clken           out  1       to RAM clken; tied 1
//  ram_reset_req       out  1       to RAM reset_req; tied 0
//  ram_readdata        in   DATA_W  from RAM q; valid 1 cycle after the read cycle
// BEHAVIOUR
//  - req_m = m_read | m_write.
//  - Acceptance is combinational: grant computed from req_m, freeze, last_grant.
//    m_waitrequest = ~(grant_m) whenever req_m = 1; waitrequest = 1 while idle.
//  - Accepted cycle: ram_chipselect = 1 and ram_* = the granted master's fields.
//    ram_write = granted m_write.
//  - Read data path:
//    - Accepted read: rd_pend <= 1, rd_owner <= granted index.
//    - Next cycle: m[rd_owner]_readdatavalid = 1 and m_readdata = ram_readdata.
//    - Back-to-back reads are legal; there is exactly one read in flight per cycle, with no buffering.
//  - Round-robin arbitration:
//    - Only one master requesting: that master wins.
//    - Both requesting: the master != last_grant wins.
//    - last_grant updates on every accepted cycle.
//  - Same master asserts read & write together: treated as a write; no readdatavalid is issued.
//  - freeze = 1: no grants, both waitrequest = 1, ram_chipselect = 0.
//    A read already pending still completes its readdatavalid.
//  - No request: ram_chipselect = 0, ram_write = 0. Address/data outputs are don't-care but driven from m0.
//  - Reset values:
//    - rd_pend = 0, rd_owner = 0, last_grant = 1, so m0 wins the first tie.
//    - Both readdatavalid = 0; readdata = 0 while not valid.
//  - Reset mid-operation: a pending read is dropped; no readdatavalid is issued after reset.
//  - Writes complete in the accept cycle. A read of the same address the next cycle returns the new data.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN
//    defined:   m0 always wins ties (fixed priority); last_grant is unused.
//    undefined: round-robin as above.
// STRUCTURE
//  - Package system_ram_arb_pkg holds:
//    - ADDR_W, DATA_W, BE_W constants.
//    - typedef logic [0:0] master_idx_t.
//    - typedef struct req_t {addr, be, rd, wr, wdata}.
//  - One sub-module, system_ram_rr_pick: 2-way picker (req[1:0], last, fixed_prio -> grant[1:0] one-hot).
//  - The top level does the muxing and the rd_pend/rd_owner registers.
// TESTING
//  1. Reset then m0 write 0x3FF, data 0xDEADBEEF, be 0xF.
//     -> m0_waitrequest = 0 same cycle; ram_write = 1.
//     m0 read 0x3FF -> m0_readdatavalid 1 cycle later with 0xDEADBEEF.
//  2. m0 and m1 read 0x001/0x002 continuously from reset, 4 cycles.
//     -> grants m0, m1, m0, m1; each readdatavalid goes to the correct master, 1 cycle after its grant.
//  3. m1 write 0x010, be 0x3, data 0x0000ABCD over prior 0x11111111.
//     -> readback 0x1111ABCD.
//  4. freeze = 1 with both requesting for 3 cycles.
//     -> both waitrequest = 1, ram_chipselect = 0.
//     A read accepted the cycle before freeze still delivers readdatavalid.
//  5. Accept an m1 read, assert reset the next cycle.
//     -> m1_readdatavalid stays 0; after reset, the first tie goes to m0.
//  6. RAM_ARB_FIXED_PRIO_EN defined, both request 4 cycles.
//     -> m0 granted all 4 cycles; m1_waitrequest = 1 throughout.

Source files
------------

// File: rtl/system_ram_arbiter_pkg.sv
// Shared constants and types for the system_RAM two-master arbiter.
package system_ram_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic [0:0] master_idx_t;

  // One master's request as seen by the arbiter.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/system_ram_arbiter_if.sv
// Avalon-MM master-side bus bundle; one instance per requester.
interface system_ram_arbiter_if;
  import system_ram_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/system_ram_arbiter_rr_pick.sv
// Two-way grant picker: a lone requester always wins; on a tie the
// master that did not win last time wins, or m0 when fixed priority is set.
module system_ram_rr_pick
  import system_ram_arb_pkg::*;
(
  input  logic [1:0]  i_req,
  input  master_idx_t i_last,
  input  logic        i_fixed_prio,
  output logic [1:0]  o_grant
);

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
        if (i_fixed_prio) begin
          o_grant = 2'b01;
        end else if (i_last == 1'b0) begin
          o_grant = 2'b10;
        end else begin
          o_grant = 2'b01;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/system_ram_arbiter.sv
// Two-requester Avalon-MM arbiter sharing the single port of the 1024x32
// on-chip RAM. One access is accepted per clock; read data returns one
// cycle after acceptance to the master that issued it.
// Build option: define RAM_ARB_FIXED_PRIO_EN to make m0 win every tie
// instead of alternating round-robin.
module system_ram_arbiter
  import system_ram_arb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_freeze,
  system_ram_arbiter_if.slave  m0,
  system_ram_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]    o_ram_address,
  output logic [BE_W-1:0]      o_ram_byteenable,
  output logic                 o_ram_chipselect,
  output logic                 o_ram_write,
  output logic [DATA_W-1:0]    o_ram_writedata,
  output logic                 o_ram_clken,
  output logic                 o_ram_reset_req,
  input  logic [DATA_W-1:0]    i_ram_readdata
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  req_t        w_req0;
  req_t        w_req1;
  req_t        w_sel;
  logic [1:0]  w_req_vec;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_rd_valid;

  logic        r_rd_pend;
  master_idx_t r_rd_owner;
  master_idx_t r_last_grant;

  assign w_req0 = '{addr: m0.address, be: m0.byteenable, rd: m0.read,
                    wr: m0.write, wdata: m0.writedata};
  assign w_req1 = '{addr: m1.address, be: m1.byteenable, rd: m1.read,
                    wr: m1.write, wdata: m1.writedata};

  // Nothing is accepted while frozen or held in reset.
  assign w_req_vec = {(w_req1.rd | w_req1.wr), (w_req0.rd | w_req0.wr)}
                     & {2{~(i_freeze | i_reset)}};

  system_ram_rr_pick u_pick (
    .i_req        (w_req_vec),
    .i_last       (r_last_grant),
    .i_fixed_prio (FIXED_PRIO),
    .o_grant      (w_grant)
  );

  assign w_accept = |w_grant;

  // Route the granted master onto the RAM port; m0 drives it when idle.
  always_comb begin
    w_sel = w_req0;
    if (w_grant[1]) begin
      w_sel = w_req1;
    end else begin
      w_sel = w_req0;
    end
  end

  assign o_ram_address    = w_sel.addr;
  assign o_ram_byteenable = w_sel.be;
  assign o_ram_writedata  = w_sel.wdata;
  assign o_ram_chipselect = w_accept;
  // Read and write together from one master is a write.
  assign o_ram_write      = w_accept & w_sel.wr;
  assign o_ram_clken      = 1'b1;
  assign o_ram_reset_req  = 1'b0;

  assign m0.waitrequest = ~w_grant[0];
  assign m1.waitrequest = ~w_grant[1];

  // Track the single in-flight read and the last winner for round-robin.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_rd_pend <= w_accept & w_sel.rd & ~w_sel.wr;
      if (w_accept) begin
        r_rd_owner   <= w_grant[1];
        r_last_grant <= w_grant[1];
      end
    end
  end

  // A read pending across a reset is dropped rather than delivered.
  assign w_rd_valid = r_rd_pend & ~i_reset;

  assign m0.readdatavalid = w_rd_valid & (r_rd_owner == 1'b0);
  assign m1.readdatavalid = w_rd_valid & (r_rd_owner == 1'b1);
  assign m0.readdata      = m0.readdatavalid ? i_ram_readdata : {DATA_W{1'b0}};
  assign m1.readdata      = m1.readdatavalid ? i_ram_readdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_system_ram_arbiter.sv
// Self-checking bench for system_ram_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_system_ram_arbiter;
  import system_ram_arb_pkg::*;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic freeze    = 1'b0;
  logic ram_clear = 1'b1;

  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic              ram_reset_req;
  logic [DATA_W-1:0] ram_q;

  system_ram_arbiter_if m0_if ();
  system_ram_arbiter_if m1_if ();

  always #5 clk = ~clk;

  system_ram_arbiter dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_freeze         (freeze),
    .m0               (m0_if),
    .m1               (m1_if),
    .o_ram_address    (ram_address),
    .o_ram_byteenable (ram_byteenable),
    .o_ram_chipselect (ram_chipselect),
    .o_ram_write      (ram_write),
    .o_ram_writedata  (ram_writedata),
    .o_ram_clken      (ram_clken),
    .o_ram_reset_req  (ram_reset_req),
    .i_ram_readdata   (ram_q)
  );

  // Behavioural single-port RAM with registered q (one-cycle read latency).
  logic [DATA_W-1:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
      ram_q <= '0;
    end else if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_q <= ram_mem[ram_address];
      end
    end
  end

  // Reference model state (transaction level).
  logic [DATA_W-1:0] ref_mem [0:1023];
  int                exp_last;
  bit                exp_pend;
  int                exp_owner;
  logic [DATA_W-1:0] exp_data;

  int                checks   = 0;
  int                failures = 0;
  int                obs_win;
  logic [DATA_W-1:0] last_rd0;
  logic [DATA_W-1:0] last_rd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input bit rd, input bit wr, input int addr,
                              input logic [3:0] be, input logic [31:0] d);
    req_t r;
    r.addr  = addr[ADDR_W-1:0];
    r.be    = be;
    r.rd    = rd;
    r.wr    = wr;
    r.wdata = d;
    return r;
  endfunction

  // One clock: drive both masters, check every output, then advance the model.
  task automatic step(input req_t q0, input req_t q1, input bit frz, input bit rst);
    int   win;
    bit   r0, r1, v0, v1;
    req_t sel;
    @(negedge clk);
    m0_if.address = q0.addr; m0_if.byteenable = q0.be; m0_if.read = q0.rd;
    m0_if.write = q0.wr; m0_if.writedata = q0.wdata;
    m1_if.address = q1.addr; m1_if.byteenable = q1.be; m1_if.read = q1.rd;
    m1_if.write = q1.wr; m1_if.writedata = q1.wdata;
    freeze = frz;
    reset  = rst;
    #1;
    r0  = q0.rd | q0.wr;
    r1  = q1.rd | q1.wr;
    win = -1;
    if (!rst && !frz) begin
      if (r0 && r1)  win = FIXED ? 0 : ((exp_last == 0) ? 1 : 0);
      else if (r0)   win = 0;
      else if (r1)   win = 1;
    end
    sel = (win == 1) ? q1 : q0;
    check("wait0", m0_if.waitrequest, win != 0);
    check("wait1", m1_if.waitrequest, win != 1);
    check("ram_cs", ram_chipselect, win >= 0);
    check("ram_we", ram_write, (win >= 0) && sel.wr);
    check("ram_addr", ram_address, sel.addr);
    if (win >= 0) begin
      check("ram_be", ram_byteenable, sel.be);
      check("ram_wd", ram_writedata, sel.wdata);
    end
    check("ram_clken", ram_clken, 1'b1);
    check("ram_rstreq", ram_reset_req, 1'b0);
    v0 = exp_pend && !rst && (exp_owner == 0);
    v1 = exp_pend && !rst && (exp_owner == 1);
    check("rdv0", m0_if.readdatavalid, v0);
    check("rdv1", m1_if.readdatavalid, v1);
    check("rdata0", m0_if.readdata, v0 ? exp_data : 32'h0);
    check("rdata1", m1_if.readdata, v1 ? exp_data : 32'h0);
    if (m0_if.readdatavalid === 1'b1) last_rd0 = m0_if.readdata;
    if (m1_if.readdatavalid === 1'b1) last_rd1 = m1_if.readdata;
    if (!m0_if.waitrequest && !m1_if.waitrequest) obs_win = 2;
    else if (!m0_if.waitrequest)                  obs_win = 0;
    else if (!m1_if.waitrequest)                  obs_win = 1;
    else                                          obs_win = -1;
    if (rst) begin
      exp_pend = 1'b0; exp_owner = 0; exp_last = 1;
    end else begin
      exp_pend = (win >= 0) && sel.rd && !sel.wr;
      if (exp_pend) begin
        exp_owner = win;
        exp_data  = ref_mem[sel.addr];
      end
      if ((win >= 0) && sel.wr)
        for (int b = 0; b < BE_W; b++)
          if (sel.be[b]) ref_mem[sel.addr][8*b +: 8] = sel.wdata[8*b +: 8];
      if (win >= 0) exp_last = win;
    end
  endtask

  initial begin
    req_t idle, ra, rb;
    idle = mk(0, 0, 0, 4'h0, 32'h0);
    m0_if.address = '0; m0_if.byteenable = '0; m0_if.read = 1'b0;
    m0_if.write = 1'b0; m0_if.writedata = '0;
    m1_if.address = '0; m1_if.byteenable = '0; m1_if.read = 1'b0;
    m1_if.write = 1'b0; m1_if.writedata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    exp_last = 1; exp_pend = 1'b0; exp_owner = 0; exp_data = '0;
    last_rd0 = '0; last_rd1 = '0; obs_win = -1;

    // Reset state
    step(idle, idle, 0, 1);
    step(idle, idle, 0, 1);
    ram_clear = 1'b0;
    step(idle, idle, 0, 0);
    check("idle_grant", obs_win, -1);

    // 1: m0 write then read-back of 0x3FF
    step(mk(0, 1, 10'h3FF, 4'hF, 32'hDEADBEEF), idle, 0, 0);
    check("t1_wr_grant", obs_win, 0);
    step(mk(1, 0, 10'h3FF, 4'hF, 32'h0), idle, 0, 0);
    step(idle, idle, 0, 0);
    check("t1_readback", last_rd0, 32'hDEADBEEF);

    // 2: both read continuously from reset
    step(idle, idle, 0, 1);
    ra = mk(1, 0, 1, 4'hF, 32'h0);
    rb = mk(1, 0, 2, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(ra, rb, 0, 0);
      check("t2_grant", obs_win, FIXED ? 0 : (i % 2));
    end
    step(idle, idle, 0, 0);

    // 3: m1 partial write over 0x11111111
    step(idle, mk(0, 1, 10'h010, 4'hF, 32'h11111111), 0, 0);
    step(idle, mk(0, 1, 10'h010, 4'h3, 32'h0000ABCD), 0, 0);
    step(idle, mk(1, 0, 10'h010, 4'h0, 32'h0), 0, 0);
    step(idle, idle, 0, 0);
    check("t3_readback", last_rd1, 32'h1111ABCD);

    // 4: freeze with both requesting; earlier read still completes
    step(mk(1, 0, 10'h3FF, 4'h0, 32'h0), idle, 0, 0);
    last_rd0 = '0;
    for (int i = 0; i < 3; i++) begin
      step(ra, rb, 1, 0);
      check("t4_frozen", obs_win, -1);
    end
    check("t4_pending_rd", last_rd0, 32'hDEADBEEF);
    step(idle, idle, 0, 0);

    // 5: reset right after an accepted m1 read
    step(idle, mk(1, 0, 10'h010, 4'h0, 32'h0), 0, 0);
    check("t5_m1_grant", obs_win, 1);
    step(idle, idle, 0, 1);
    step(idle, idle, 0, 0);
    step(ra, rb, 0, 0);
    check("t5_first_tie", obs_win, 0);
    step(idle, idle, 0, 0);

    // 6: ties for 4 cycles (fixed priority build keeps m0)
    step(idle, idle, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 1, 4 + i, 4'hF, 32'hA0 + i), mk(0, 1, 8 + i, 4'hF, 32'hB0 + i), 0, 0);
      check("t6_grant", obs_win, FIXED ? 0 : (i % 2));
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ra = mk($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 15),
              4'($urandom_range(0, 15)), $urandom);
      rb = mk($urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 15),
              4'($urandom_range(0, 15)), $urandom);
      step(ra, rb, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    step(idle, idle, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
